// File: rtl/axi_rd_burst_splitter_if.sv
// axi_rd_burst_splitter_if: AXI read address/data channels plus the single-beat APB request/response link.
interface axi_rd_burst_splitter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready, req_ready, rsp_valid, rsp_rdata, rsp_slverr,
    output arready, rid, rdata, rresp, rlast, rvalid, req_valid, req_addr
  );
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready, req_ready, rsp_valid, rsp_rdata, rsp_slverr,
    input  arready, rid, rdata, rresp, rlast, rvalid, req_valid, req_addr
  );
endinterface

// File: rtl/axi_rd_burst_splitter.sv
// axi_rd_burst_splitter: splits one AXI read burst at a time into single-beat APB read requests.
module axi_rd_burst_splitter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input logic clk,
  input logic rst_n,
  axi_rd_burst_splitter_if.slave bus
);
  localparam int MAX_SIZE = $clog2(DATA_WIDTH/8);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESP} state_t;
  state_t state, state_nx;
  logic init, err_burst, ar_bad, ar_hs, r_hs, last, arready;
  logic [ID_WIDTH-1:0] id;
  logic [ADDR_WIDTH-1:0] cur_addr, next_addr, step, wrap_mask;
  logic [7:0] len, beat_cnt;
  logic [2:0] size;
  logic [1:0] burst, rresp;
  logic [DATA_WIDTH-1:0] rdata;
  // init keeps arready low for the first cycle after reset release
  assign arready = init & (state == IDLE);
  assign ar_hs = arready & bus.arvalid;
  assign r_hs = (state == RESP) & bus.rready;
  assign last = beat_cnt == len;
  assign ar_bad = (bus.arburst == 2'b11) || (bus.arsize > 3'(MAX_SIZE)) ||
                  ((bus.arburst == 2'b10) && (!(bus.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                   (|(bus.araddr & ~({ADDR_WIDTH{1'b1}} << bus.arsize)))));
  assign step = ADDR_WIDTH'(1) << size;
  assign wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
  assign next_addr = (burst == 2'b00) ? cur_addr :
                     (burst == 2'b01) ? cur_addr + step :
                     (cur_addr & ~wrap_mask) | ((cur_addr + step) & wrap_mask);
  assign bus.arready = arready;
  assign bus.rid = id;
  assign bus.rdata = rdata;
  assign bus.rresp = rresp;
  assign bus.rvalid = state == RESP;
  assign bus.rlast = (state == RESP) & last;
  assign bus.req_valid = state == REQ;
  assign bus.req_addr = cur_addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (ar_hs) state_nx = ar_bad ? RESP : REQ;
      REQ:      if (bus.req_ready) state_nx = WAIT_RSP;
      WAIT_RSP: if (bus.rsp_valid) state_nx = RESP;
      RESP:     if (r_hs) state_nx = last ? IDLE : err_burst ? RESP : REQ;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      init <= 1'b0;
      err_burst <= 1'b0;
      id <= '0;
      cur_addr <= '0;
      len <= '0;
      size <= '0;
      burst <= '0;
      beat_cnt <= '0;
      rdata <= '0;
      rresp <= '0;
    end else begin
      init <= 1'b1;
      if (ar_hs) begin
        id <= bus.arid;
        cur_addr <= bus.araddr;
        len <= bus.arlen;
        size <= bus.arsize;
        burst <= bus.arburst;
        beat_cnt <= '0;
        err_burst <= ar_bad;
        rdata <= '0;
        rresp <= ar_bad ? 2'b10 : 2'b00;
      end
      if ((state == WAIT_RSP) && bus.rsp_valid) begin
        rdata <= bus.rsp_rdata;
        rresp <= bus.rsp_slverr ? 2'b10 : 2'b00;
      end
      if (r_hs && !last) begin
        beat_cnt <= beat_cnt + 8'd1;
        cur_addr <= next_addr;
      end
    end
endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// tb_axi_rd_burst_splitter: directed bursts checked every cycle against a queue-based burst model.
module tb_axi_rd_burst_splitter;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  axi_rd_burst_splitter_if bus();
  axi_rd_burst_splitter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_addr[$];
  beat_t exp_r[$];
  int beats_left = 0;
  int since = 0;
  bit req_fired = 0;
  logic [3:0] m_id = 0;
  int m_len = 0;
  int m_beat = 0;
  int err_beat = -1;
  int lat = 0;
  logic [31:0] rsp_base = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask
  function automatic bit legal(logic [31:0] a, logic [7:0] l, logic [2:0] s, logic [1:0] b);
    if (b == 2'b11 || s > 3'd2) return 0;
    if (b == 2'b10) return (l == 1 || l == 3 || l == 7 || l == 15) && (a % (32'd1 << s) == 0);
    return 1;
  endfunction
  function automatic logic [31:0] beat_addr(logic [31:0] a, int i, logic [7:0] l, logic [2:0] s, logic [1:0] b);
    logic [31:0] st, wl, base;
    st = 32'd1 << s;
    if (b == 2'b00) return a;
    if (b == 2'b01) return a + 32'(i) * st;
    wl = (32'(l) + 1) * st;
    base = a - (a % wl);
    return base + (((a - base) + 32'(i) * st) % wl);
  endfunction
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_arready", bus.arready, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_rlast", bus.rlast, 0);
      chk("rst_req_valid", bus.req_valid, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_rresp", bus.rresp, 0);
      chk("rst_rid", bus.rid, 0);
      chk("rst_req_addr", bus.req_addr, 0);
      exp_addr.delete();
      exp_r.delete();
      beats_left = 0;
      since = 0;
    end else begin
      if (since < 2) since++;
      chk("arready", bus.arready, (since >= 2) && (beats_left == 0));
      if (bus.req_valid) begin
        if (exp_addr.size() == 0) fail("req_unexpected");
        else chk("req_addr", bus.req_addr, exp_addr[0]);
      end
      if (bus.rvalid) begin
        if (exp_r.size() == 0) fail("rvalid_unexpected");
        else begin
          chk("rdata", bus.rdata, exp_r[0].data);
          chk("rresp", bus.rresp, exp_r[0].resp);
          chk("rlast", bus.rlast, exp_r[0].last);
          chk("rid", bus.rid, exp_r[0].id);
        end
      end
      if (bus.arvalid && bus.arready) begin
        m_id = bus.arid;
        m_len = int'(bus.arlen);
        m_beat = 0;
        beats_left += m_len + 1;
        for (int i = 0; i <= m_len; i++)
          if (legal(bus.araddr, bus.arlen, bus.arsize, bus.arburst))
            exp_addr.push_back(beat_addr(bus.araddr, i, bus.arlen, bus.arsize, bus.arburst));
          else begin
            beat_t e;
            e.data = 0; e.resp = 2'b10; e.last = (i == m_len); e.id = bus.arid;
            exp_r.push_back(e);
          end
      end
      if (bus.req_valid && bus.req_ready) begin
        if (exp_addr.size() > 0) void'(exp_addr.pop_front());
        req_fired = 1;
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r.size() > 0) void'(exp_r.pop_front());
        beats_left--;
      end
    end
  end
  initial begin
    int cnt;
    bit waiting;
    cnt = 0;
    waiting = 0;
    bus.rsp_valid = 0;
    bus.rsp_rdata = 0;
    bus.rsp_slverr = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_valid = 0;
      if (!rst_n) begin
        waiting = 0;
        req_fired = 0;
      end else begin
        if (req_fired) begin
          req_fired = 0;
          waiting = 1;
          cnt = lat;
        end
        if (waiting) begin
          if (cnt == 0) begin
            beat_t e;
            waiting = 0;
            bus.rsp_valid = 1;
            bus.rsp_rdata = rsp_base + 32'(m_beat);
            bus.rsp_slverr = (m_beat == err_beat);
            e.data = rsp_base + 32'(m_beat);
            e.resp = (m_beat == err_beat) ? 2'b10 : 2'b00;
            e.last = (m_beat == m_len);
            e.id = m_id;
            exp_r.push_back(e);
            m_beat++;
          end else cnt--;
        end
      end
    end
  end
  task automatic do_ar(logic [3:0] id, logic [31:0] a, logic [7:0] l, logic [2:0] s, logic [1:0] b);
    int k;
    @(posedge clk);
    #1;
    bus.arid = id; bus.araddr = a; bus.arlen = l; bus.arsize = s; bus.arburst = b; bus.arvalid = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.arready && k < 50);
    if (!bus.arready) fail("ar_timeout");
    @(posedge clk);
    #1;
    bus.arvalid = 0;
    @(negedge clk);
    chk("ar_next_req_valid", bus.req_valid, legal(a, l, s, b));
    chk("ar_next_rvalid", bus.rvalid, !legal(a, l, s, b));
  endtask
  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(beats_left == 0 && bus.arready) && k < 500);
    if (k >= 500) fail("idle_timeout");
    chk("queues_drained", exp_addr.size() + exp_r.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.rready = 1;
    bus.req_ready = 1;
    chk("pin_incr_b3", beat_addr(32'h1000, 3, 8'd3, 3'd2, 2'b01), 32'h100C);
    chk("pin_wrap_b1", beat_addr(32'h2008, 1, 8'd3, 3'd2, 2'b10), 32'h200C);
    chk("pin_wrap_b2", beat_addr(32'h2008, 2, 8'd3, 3'd2, 2'b10), 32'h2000);
    chk("pin_wrap_b3", beat_addr(32'h2008, 3, 8'd3, 3'd2, 2'b10), 32'h2004);
    chk("pin_fixed_b2", beat_addr(32'h30, 2, 8'd2, 3'd2, 2'b00), 32'h30);
    chk("pin_incr_ovf", beat_addr(32'hFFFF_FFFC, 1, 8'd1, 3'd2, 2'b01), 32'h0);
    chk("pin_illegal_11", legal(32'h0, 8'd1, 3'd2, 2'b11), 0);
    chk("pin_illegal_wraplen", legal(32'h0, 8'd2, 3'd2, 2'b10), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("arready_post_rst", bus.arready, 0);
    @(negedge clk);
    chk("arready_rise", bus.arready, 1);
    rsp_base = 32'hA0; err_beat = -1; lat = 1;
    do_ar(4'h5, 32'h1000, 8'd3, 3'd2, 2'b01);
    chk("incr_first_addr", bus.req_addr, 32'h1000);
    wait_idle();
    rsp_base = 32'hB0; lat = 0;
    do_ar(4'h6, 32'h2008, 8'd3, 3'd2, 2'b10);
    chk("wrap_first_addr", bus.req_addr, 32'h2008);
    wait_idle();
    bus.req_ready = 0;
    rsp_base = 32'h10; lat = 2;
    do_ar(4'h7, 32'h30, 8'd2, 3'd2, 2'b00);
    repeat (3) begin
      @(negedge clk);
      chk("hold_req_valid", bus.req_valid, 1);
      chk("hold_req_addr", bus.req_addr, 32'h30);
    end
    @(posedge clk);
    #1;
    bus.req_ready = 1;
    wait_idle();
    rsp_base = 32'h200; err_beat = 1; lat = 1;
    do_ar(4'h8, 32'h400, 8'd2, 3'd2, 2'b01);
    wait_idle();
    err_beat = -1;
    do_ar(4'hA, 32'h500, 8'd1, 3'd2, 2'b11);
    chk("bad11_rdata", bus.rdata, 0);
    chk("bad11_rresp", bus.rresp, 2'b10);
    wait_idle();
    do_ar(4'hB, 32'h600, 8'd0, 3'd3, 2'b01);
    wait_idle();
    do_ar(4'hC, 32'h700, 8'd2, 3'd2, 2'b10);
    wait_idle();
    do_ar(4'hD, 32'h2006, 8'd3, 3'd2, 2'b10);
    wait_idle();
    rsp_base = 32'h300;
    do_ar(4'hE, 32'h105, 8'd7, 3'd0, 2'b10);
    wait_idle();
    do_ar(4'hF, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
    wait_idle();
    bus.rready = 0;
    rsp_base = 32'h50; lat = 0;
    do_ar(4'h1, 32'h4000, 8'd1, 3'd2, 2'b01);
    begin
      int k;
      k = 0;
      while (!bus.rvalid && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!bus.rvalid) fail("bp_rvalid_timeout");
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_rvalid", bus.rvalid, 1);
      chk("bp_rdata", bus.rdata, 32'h50);
      chk("bp_req_valid", bus.req_valid, 0);
    end
    @(posedge clk);
    #1;
    bus.rready = 1;
    wait_idle();
    lat = 4;
    do_ar(4'h9, 32'h5000, 8'd3, 3'd2, 2'b01);
    @(posedge clk);
    #1;
    rst_n = 0;
    @(negedge clk);
    chk("midrst_req_valid", bus.req_valid, 0);
    chk("midrst_rvalid", bus.rvalid, 0);
    chk("midrst_req_addr", bus.req_addr, 0);
    chk("midrst_rid", bus.rid, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    lat = 0; rsp_base = 32'hC0;
    do_ar(4'h3, 32'h6000, 8'd1, 3'd2, 2'b01);
    chk("post_rst_addr", bus.req_addr, 32'h6000);
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_burst_splitter.md
# axi_rd_burst_splitter

AXI4 read-channel slave front end of the AXI2APB bridge. It accepts one AR burst at a time and splits it into single-beat read requests to the downstream APB master stage. It then returns each APB read result as one R beat, with RLAST on the final beat. It sits directly upstream of the APB master and owns all AXI burst address arithmetic, so the APB stage only ever sees single-word reads.

## Interface
- ADDR_WIDTH, 32, AXI/APB address width
- DATA_WIDTH, 32, data width; must be 32 or 64
- ID_WIDTH, 4, AXI ID width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- arid  in  ID_WIDTH  read burst ID
- araddr  in  ADDR_WIDTH  burst start address
- arlen  in  8  beats minus one
- arsize  in  3  log2 bytes per beat
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  ID_WIDTH  returned ID
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- rlast  out  1  final beat of burst
- rvalid  out  1  R valid
- rready  in  1  R ready
- req_valid  out  1  single-beat read request to APB master
- req_addr  out  ADDR_WIDTH  request address
- req_ready  in  1  APB master accepts request
- rsp_valid  in  1  one-cycle pulse: APB transfer completed
- rsp_rdata  in  DATA_WIDTH  APB read data, valid with rsp_valid
- rsp_slverr  in  1  APB error, valid with rsp_valid

## Operation
- States: IDLE, REQ, WAIT_RSP, RESP.
- IDLE
  - arready=1.
  - On arvalid&arready, register arid, araddr, arlen, arsize and arburst, and clear beat_cnt.
  - If the burst is illegal, set err_burst; otherwise clear it.
  - Go to REQ, or to RESP if err_burst is set.
- Illegal burst conditions:
  - arburst=11.
  - arsize > log2(DATA_WIDTH/8).
  - WRAP with arlen not in {1,3,7,15}.
  - WRAP with araddr not aligned to 2^arsize.
- REQ
  - req_valid=1, req_addr=cur_addr.
  - On req_ready, go to WAIT_RSP.
- WAIT_RSP
  - On rsp_valid, register rdata=rsp_rdata and rresp=rsp_slverr?10:00.
  - Go to RESP.
  - rsp_valid in any other state is ignored.
- RESP
  - rvalid=1, rlast=(beat_cnt==arlen).
  - With err_burst set: rdata=0, rresp=10, and no APB request is issued.
  - On rvalid&rready:
    - if rlast, go to IDLE;
    - else beat_cnt+1, cur_addr=next_addr, and go to REQ (RESP again if err_burst).
- next_addr, with step=2^arsize:
  - FIXED: unchanged.
  - INCR: cur_addr+step, modulo 2^ADDR_WIDTH.
  - WRAP: wrap_len=(arlen+1)*step; the bits of cur_addr below log2(wrap_len) increment by step and wrap to zero; the upper bits are held.
- rid holds the captured arid for the whole burst.
- A burst is never aborted: every accepted AR yields exactly arlen+1 R beats.

## Timing
- Reset values:
  - arready=0; rvalid, rlast and req_valid are 0.
  - rdata, rresp, rid and req_addr are 0.
  - State is IDLE and arready rises to 1 on the first clock after reset release.
- All outputs are registered or decoded from state; there is no combinational path from any input to any output.
- AR handshake at cycle 0 gives req_valid=1 at cycle 1.
- req_ready at cycle k gives req_valid=0 at cycle k+1.
- rsp_valid at cycle m gives rvalid=1 at cycle m+1.
- R handshake at cycle n gives either the next req_valid or arready=1 at cycle n+1.
- Minimum per-beat overhead is 3 cycles plus APB latency. Only one request is ever outstanding.
- req_valid and req_addr stay stable until req_ready.
- rvalid, rdata, rresp, rlast and rid stay stable until rready.
- arready is 0 in every state except IDLE; a second AR is never accepted mid-burst.
- Reset asserted mid-burst: all state is discarded immediately and outputs take reset values; partial bursts are not resumed.

## Test plan
- INCR, araddr=0x1000, arlen=3, arsize=2, rready=1, APB returns 0xA0..0xA3:
  - req_addr is 0x1000, 0x1004, 0x1008, 0x100C;
  - R beats are 0xA0..0xA3, rresp=00, rlast only on beat 3, rid=arid.
- WRAP, araddr=0x2008, arlen=3, arsize=2:
  - req_addr is 0x2008, 0x200C, 0x2000, 0x2004.
- FIXED, araddr=0x30, arlen=2: three requests, all to 0x30.
- rsp_slverr=1 on beat 1 of a 3-beat INCR:
  - beat 1 has rresp=10, beats 0 and 2 have 00;
  - all three beats are returned and rlast is on beat 2.
- arburst=11 with arlen=1:
  - req_valid is never asserted;
  - two beats with rresp=10 and rdata=0, rlast on the second.
- Backpressure and reset:
  - rready=0 for 5 cycles holds rvalid/rdata stable and req_valid stays 0;
  - rst_n low in WAIT_RSP forces all outputs to reset values;
  - a new AR is accepted normally after release.
